// File: rtl/fpmul_pkg.sv
// fpmul_pkg: shared types and helpers for the parametrised floating-point
// multiplier (fpmul_pipe) and its round/pack core (fp_round_pack).
//   - fp_class_e   : operand / result class (zero, normal, inf, NaN)
//   - FLG_*        : bit positions inside the 4-bit exception flag vector
//   - fp_bias/qnan : format constants derived from the field widths
//   - fp_sign/exp/frac/classify : field extraction on a word zero-extended
//                    to 64 bits (formats up to 64 bits wide)
package fpmul_pkg;

    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_e;

    localparam int FLG_INEXACT   = 0;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_INVALID   = 3;

    function automatic int fp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Canonical quiet NaN: positive, exponent all ones, fraction MSB set.
    function automatic logic [63:0] fp_qnan(input int ew, input int mw);
        return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
    endfunction

    function automatic logic fp_sign(input logic [63:0] x, input int ew, input int mw);
        return x[ew + mw];
    endfunction

    function automatic logic [63:0] fp_exp(input logic [63:0] x, input int ew, input int mw);
        return (x >> mw) & ((64'd1 << ew) - 64'd1);
    endfunction

    function automatic logic [63:0] fp_frac(input logic [63:0] x, input int mw);
        return x & ((64'd1 << mw) - 64'd1);
    endfunction

    // Subnormals (exp == 0, frac != 0) classify as zero: they are flushed.
    function automatic fp_class_e fp_classify(input logic [63:0] x, input int ew, input int mw);
        logic [63:0] e;
        logic [63:0] f;
        e = fp_exp(x, ew, mw);
        f = fp_frac(x, mw);
        if (e == ((64'd1 << ew) - 64'd1)) return (f != 64'd0) ? FP_NAN : FP_INF;
        else if (e == 64'd0)              return FP_ZERO;
        else                              return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: combinational normalise / round-to-nearest-even / pack core.
// Ports:
//   sgn_i   result sign
//   exp_i   biased result exponent before normalisation, EXP_W+2 bits,
//           two's complement (may be negative or above the format range)
//   prod_i  unsigned mantissa product {1,f1}*{1,f2}, 2*(MAN_W+1) bits
//   cls_i   result class decided from the operand specials
//   word_o  packed {sign, exp, frac} result
//   flags_o {invalid, overflow, underflow, inexact}
module fp_round_pack
    import fpmul_pkg::*;
#(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 7,
    localparam int W     = 1 + EXP_W + MAN_W,
    localparam int PW    = 2 * (MAN_W + 1)
) (
    input  logic             sgn_i,
    input  logic [EXP_W+1:0] exp_i,
    input  logic [PW-1:0]    prod_i,
    input  fp_class_e        cls_i,
    output logic [W-1:0]     word_o,
    output logic [3:0]       flags_o
);

    localparam logic [W-1:0]     QNAN = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EXP_W+1:0] EMAX = {2'b00, {EXP_W{1'b1}}};

    logic [PW-1:0]    norm;
    logic [EXP_W+1:0] e_n, e_f;
    logic [MAN_W-1:0] frac, frac_r;
    logic             g, r, st, inc, carry, ovf, unf;

    always_comb begin
        // Product of two [1,2) mantissas lies in [1,4): at most one right
        // shift. Left-align so the hidden bit always sits at PW-1.
        norm   = prod_i[PW-1] ? prod_i : (prod_i << 1);
        e_n    = exp_i + {{(EXP_W+1){1'b0}}, prod_i[PW-1]};
        frac   = norm[PW-2 -: MAN_W];
        g      = norm[PW-2-MAN_W];
        r      = norm[PW-3-MAN_W];
        st     = |norm[PW-4-MAN_W:0];
        inc    = g & (r | st | frac[0]);
        // All-ones fraction plus increment wraps to zero and bumps the exponent.
        frac_r = frac + {{(MAN_W-1){1'b0}}, inc};
        carry  = inc & (&frac);
        e_f    = e_n + {{(EXP_W+1){1'b0}}, carry};
        ovf    = !e_f[EXP_W+1] && (e_f >= EMAX);
        unf    = e_f[EXP_W+1] || (e_f == '0);

        word_o  = '0;
        flags_o = '0;
        case (cls_i)
            FP_NAN: begin
                word_o               = QNAN;
                flags_o[FLG_INVALID] = 1'b1;
            end
            FP_INF:  word_o = {sgn_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            FP_ZERO: word_o = {sgn_i, {(W-1){1'b0}}};
            default: begin
                if (ovf) begin
                    word_o                = {sgn_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_o[FLG_OVERFLOW] = 1'b1;
                    flags_o[FLG_INEXACT]  = 1'b1;
                end else if (unf) begin
                    word_o                 = {sgn_i, {(W-1){1'b0}}};
                    flags_o[FLG_UNDERFLOW] = 1'b1;
                    flags_o[FLG_INEXACT]   = 1'b1;
                end else begin
                    word_o               = {sgn_i, e_f[EXP_W-1:0], frac_r};
                    flags_o[FLG_INEXACT] = g | r | st;
                end
            end
        endcase
    end

endmodule

// File: rtl/fpmul_pipe.sv
// fpmul_pipe: fully pipelined floating-point multiplier, widths set by
// EXP_W/MAN_W (defaults: bf16). One op per cycle; an op sampled at edge N
// (valid=1, en=1) is presented on y with a one-cycle ready strobe after
// edge N+3. en=0 freezes every register, including the valid pipe.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-low reset (wins over en)
//   en     pipeline advance
//   valid  x1/x2 carry an operation
//   x1,x2  operands {sign, exp, frac}, W bits
//   y      registered product
//   ready  y holds a new result
//   flags  {invalid, overflow, underflow, inexact}, aligned with ready,
//          zero otherwise; present only when FPMUL_FLAGS_EN is defined
// Ranks: operand capture -> unpack/classify/exponent -> mantissa product
//        -> round/pack into y.
module fpmul_pipe
    import fpmul_pkg::*;
#(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 7,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         valid,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    output logic [W-1:0] y,
    output logic         ready
`ifdef FPMUL_FLAGS_EN
    ,
    output logic [3:0]   flags
`endif
);

    localparam int               PW   = 2 * (MAN_W + 1);
    localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'(fp_bias(EXP_W));

    // vld_q[3] is the ready strobe itself
    logic [3:0]       vld_q;
    logic [W-1:0]     op_a_q, op_b_q;
    logic             s1_sgn_q, s1_sgn_d;
    logic [EXP_W+1:0] s1_exp_q, s1_exp_d;
    logic [MAN_W:0]   s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    fp_class_e        s1_cls_q, s1_cls_d;
    logic             s2_sgn_q;
    logic [EXP_W+1:0] s2_exp_q;
    logic [PW-1:0]    s2_prod_q, s2_prod_d;
    fp_class_e        s2_cls_q;
    logic [W-1:0]     y_q;
    logic [3:0]       flags_q;
    fp_class_e        cls_a, cls_b;
    logic [W-1:0]     rp_word;
    logic [3:0]       rp_flags;

    always_comb begin
        cls_a = fp_classify(64'(op_a_q), EXP_W, MAN_W);
        cls_b = fp_classify(64'(op_b_q), EXP_W, MAN_W);
        if (cls_a == FP_NAN || cls_b == FP_NAN)
            s1_cls_d = FP_NAN;
        else if ((cls_a == FP_INF && cls_b == FP_ZERO) || (cls_a == FP_ZERO && cls_b == FP_INF))
            s1_cls_d = FP_NAN;
        else if (cls_a == FP_INF || cls_b == FP_INF)
            s1_cls_d = FP_INF;
        else if (cls_a == FP_ZERO || cls_b == FP_ZERO)
            s1_cls_d = FP_ZERO;
        else
            s1_cls_d = FP_NORM;
        s1_sgn_d = fp_sign(64'(op_a_q), EXP_W, MAN_W) ^ fp_sign(64'(op_b_q), EXP_W, MAN_W);
        s1_exp_d = {2'b00, EXP_W'(fp_exp(64'(op_a_q), EXP_W, MAN_W))}
                 + {2'b00, EXP_W'(fp_exp(64'(op_b_q), EXP_W, MAN_W))} - BIAS;
        s1_ma_d  = {1'b1, MAN_W'(fp_frac(64'(op_a_q), MAN_W))};
        s1_mb_d  = {1'b1, MAN_W'(fp_frac(64'(op_b_q), MAN_W))};
        s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
    end

    fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_rp (
        .sgn_i   (s2_sgn_q),
        .exp_i   (s2_exp_q),
        .prod_i  (s2_prod_q),
        .cls_i   (s2_cls_q),
        .word_o  (rp_word),
        .flags_o (rp_flags)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            s1_sgn_q  <= 1'b0;
            s1_exp_q  <= '0;
            s1_ma_q   <= '0;
            s1_mb_q   <= '0;
            s1_cls_q  <= FP_ZERO;
            s2_sgn_q  <= 1'b0;
            s2_exp_q  <= '0;
            s2_prod_q <= '0;
            s2_cls_q  <= FP_ZERO;
            y_q       <= '0;
            flags_q   <= '0;
        end else if (en) begin
            vld_q     <= {vld_q[2:0], valid};
            op_a_q    <= x1;
            op_b_q    <= x2;
            s1_sgn_q  <= s1_sgn_d;
            s1_exp_q  <= s1_exp_d;
            s1_ma_q   <= s1_ma_d;
            s1_mb_q   <= s1_mb_d;
            s1_cls_q  <= s1_cls_d;
            s2_sgn_q  <= s1_sgn_q;
            s2_exp_q  <= s1_exp_q;
            s2_prod_q <= s2_prod_d;
            s2_cls_q  <= s1_cls_q;
            // bubbles leave y untouched; flags only mean something with ready
            if (vld_q[2]) y_q <= rp_word;
            flags_q   <= vld_q[2] ? rp_flags : 4'b0000;
        end
    end

    assign y     = y_q;
    assign ready = vld_q[3];

`ifdef FPMUL_FLAGS_EN
    assign flags = flags_q;
`else
    logic unused_flags;
    assign unused_flags = ^{flags_q, rp_flags};
`endif

endmodule
